// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage sequencer: walks NUM_STAGES stages of STAGE_CYCLES butterfly slots each, one-hot en/sel/bfly_idx.
// Latency: en[0] one cycle after start is sampled; done one cycle after the last en cycle (NUM_STAGES*STAGE_CYCLES+1 from start).
// Backpressure: stall freezes stage/idx and gates en combinationally; abort cancels to IDLE. Option: FFT_SEQ_BACK_TO_BACK_EN.
module fft_stage_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int STAGE_CYCLES = 16,
  localparam int SEL_W = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int CNT_W = ($clog2(STAGE_CYCLES) > 1) ? $clog2(STAGE_CYCLES) : 1
) (
  input  logic                  clk_50,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] en,
  output logic [SEL_W-1:0]      sel,
  output logic [CNT_W-1:0]      bfly_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SEL_W-1:0] STG_LAST = SEL_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(STAGE_CYCLES - 1);

  logic [1:0]       state;
  logic [SEL_W-1:0] stage;
  logic [CNT_W-1:0] idx;
  logic             stage_bad;

  // A stage value past the last stage can only come from corruption; treat it as a recovery trigger.
  assign stage_bad = (int'(stage) >= NUM_STAGES);

  // Sequencing state: abort beats stall, stall beats counting; sel/idx return to 0 whenever IDLE is entered.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      stage <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stage <= '0;
          idx   <= '0;
          if (start && !abort) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort || stage_bad) begin
            state <= S_IDLE;
            stage <= '0;
            idx   <= '0;
          end else if (!stall) begin
            if (idx == IDX_LAST) begin
              if (stage == STG_LAST) begin
                // Hold the final stage/idx so they stay visible during DONE.
                state <= S_DONE;
              end else begin
                stage <= stage + SEL_W'(1);
                idx   <= '0;
              end
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          stage <= '0;
          idx   <= '0;
`ifdef FFT_SEQ_BACK_TO_BACK_EN
          // Chain straight into the next frame, skipping the IDLE cycle.
          if (start && !abort) begin
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: begin
          state <= S_IDLE;
          stage <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // One-hot enable of the active stage; stall is the only input that reaches an output combinationally.
  always_comb begin
    en = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      en[k] = (state == S_RUN) && !stall && (int'(stage) == k);
    end
  end

  assign sel      = stage;
  assign bfly_idx = idx;
  assign busy     = (state == S_RUN) || (state == S_DONE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;

  logic       clk_50;
  logic       rst_n;
  logic       start, stall, abort;
  logic [4:0] en;
  logic [2:0] sel;
  logic [1:0] bfly_idx;
  logic       busy, done;

  logic       start_b, stall_b, abort_b;
  logic [1:0] en_b;
  logic [0:0] sel_b;
  logic [0:0] idx_b;
  logic       busy_b, done_b;

  int total = 0;
  int bad   = 0;

  fft_stage_sequencer #(.NUM_STAGES(5), .STAGE_CYCLES(4)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
    .en(en), .sel(sel), .bfly_idx(bfly_idx), .busy(busy), .done(done)
  );

  fft_stage_sequencer #(.NUM_STAGES(2), .STAGE_CYCLES(1)) dut_b (
    .clk_50(clk_50), .rst_n(rst_n), .start(start_b), .stall(stall_b), .abort(abort_b),
    .en(en_b), .sel(sel_b), .bfly_idx(idx_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_50);
    #1;
  endtask

  task automatic check_idle(input string tag, input int c);
    chk({tag, "_en"},   c, 32'(en),       32'd0);
    chk({tag, "_sel"},  c, 32'(sel),      32'd0);
    chk({tag, "_idx"},  c, 32'(bfly_idx), 32'd0);
    chk({tag, "_busy"}, c, 32'(busy),     32'd0);
    chk({tag, "_done"}, c, 32'(done),     32'd0);
  endtask

  // Caller is in cycle 0 with start already high. Stall is high for cycles lo..hi.
  // Checks every cycle through the done cycle using slot count k = cycles run minus stalled cycles.
  task automatic run_frame(input int lo, input int hi, input bit hold);
    int  nst;
    int  k;
    bit  st;
    nst = 0;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      start = hold;
      st    = (c >= lo) && (c <= hi);
      stall = st;
      #1;
      k = c - 1 - nst;
      if (k < 20) begin
        chk("run_en",   c, 32'(en),       st ? 32'd0 : (32'd1 << (k / 4)));
        chk("run_sel",  c, 32'(sel),      32'(k / 4));
        chk("run_idx",  c, 32'(bfly_idx), 32'(k % 4));
        chk("run_busy", c, 32'(busy),     32'd1);
        chk("run_done", c, 32'(done),     32'd0);
      end else begin
        chk("done_en",   c, 32'(en),       32'd0);
        chk("done_sel",  c, 32'(sel),      32'd4);
        chk("done_idx",  c, 32'(bfly_idx), 32'd3);
        chk("done_busy", c, 32'(busy),     32'd1);
        chk("done_done", c, 32'(done),     32'd1);
        break;
      end
      if (st) nst++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    start_b = 1'b0; stall_b = 1'b0; abort_b = 1'b0;
    #3;
    check_idle("reset", 0);
    chk("reset_b_busy", 0, 32'(busy_b), 32'd0);
    chk("reset_b_en",   0, 32'(en_b),   32'd0);
    #5;
    rst_n = 1'b1;

    // Plain transform, then one idle cycle.
    next_cycle(); start = 1'b1;
    run_frame(100, 0, 1'b0);
    next_cycle(); start = 1'b0; stall = 1'b0; #1;
    check_idle("t1_after", 22);

    // Stall during cycles 6..8 pushes done to cycle 24.
    next_cycle(); start = 1'b1;
    run_frame(6, 8, 1'b0);
    next_cycle(); start = 1'b0; stall = 1'b0; #1;
    check_idle("t2_after", 25);

    // Stall held across DONE does not delay done nor extend busy.
    next_cycle(); start = 1'b1;
    run_frame(21, 22, 1'b0);
    next_cycle(); start = 1'b0; stall = 1'b1; #1;
    check_idle("stall_done", 22);
    stall = 1'b0;

    // Abort at cycle 10, then abort+start together in IDLE, then a full restart.
    next_cycle(); start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle(); start = 1'b0; abort = (c == 10); #1;
      chk("ab_en", c, 32'(en), 32'd1 << ((c - 1) / 4));
    end
    next_cycle(); abort = 1'b1; start = 1'b1; #1;
    check_idle("ab_11", 11);
    next_cycle(); abort = 1'b0; start = 1'b1; #1;
    check_idle("ab_start", 12);
    run_frame(100, 0, 1'b0);
    next_cycle(); start = 1'b0; #1;
    check_idle("t3_after", 22);

    // start held high throughout: no retrigger while busy.
    next_cycle(); start = 1'b1;
    run_frame(100, 0, 1'b1);
    next_cycle(); start = 1'b1; #1;
`ifdef FFT_SEQ_BACK_TO_BACK_EN
    chk("b2b_en22",   22, 32'(en),       32'd1);
    chk("b2b_busy22", 22, 32'(busy),     32'd1);
    chk("b2b_idx22",  22, 32'(bfly_idx), 32'd0);
`else
    chk("b2b_en22",   22, 32'(en),   32'd0);
    chk("b2b_busy22", 22, 32'(busy), 32'd0);
`endif
    next_cycle(); start = 1'b0; abort = 1'b1; #1;
    chk("b2b_en23",   23, 32'(en),   32'd1);
    chk("b2b_busy23", 23, 32'(busy), 32'd1);
`ifdef FFT_SEQ_BACK_TO_BACK_EN
    chk("b2b_idx23",  23, 32'(bfly_idx), 32'd1);
`else
    chk("b2b_idx23",  23, 32'(bfly_idx), 32'd0);
`endif
    next_cycle(); abort = 1'b0; #1;
    check_idle("b2b_abort", 24);

    // Asynchronous reset mid-run at cycle 7.
    next_cycle(); start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); start = 1'b0; #1;
    end
    chk("rst_pre_sel", 7, 32'(sel),      32'd1);
    chk("rst_pre_idx", 7, 32'(bfly_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid", 7);
    #2;
    rst_n = 1'b1;
    next_cycle(); #1;
    check_idle("rst_after", 8);

    // NUM_STAGES=2, STAGE_CYCLES=1 instance.
    next_cycle(); start_b = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); start_b = 1'b0; #1;
      case (c)
        1: begin
          chk("sc1_en",   c, 32'(en_b),   32'd1);
          chk("sc1_sel",  c, 32'(sel_b),  32'd0);
          chk("sc1_idx",  c, 32'(idx_b),  32'd0);
          chk("sc1_done", c, 32'(done_b), 32'd0);
        end
        2: begin
          chk("sc1_en",   c, 32'(en_b),   32'd2);
          chk("sc1_sel",  c, 32'(sel_b),  32'd1);
          chk("sc1_idx",  c, 32'(idx_b),  32'd0);
          chk("sc1_done", c, 32'(done_b), 32'd0);
        end
        3: begin
          chk("sc1_en",   c, 32'(en_b),   32'd0);
          chk("sc1_busy", c, 32'(busy_b), 32'd1);
          chk("sc1_done", c, 32'(done_b), 32'd1);
        end
        default: begin
          chk("sc1_en",   c, 32'(en_b),   32'd0);
          chk("sc1_busy", c, 32'(busy_b), 32'd0);
          chk("sc1_done", c, 32'(done_b), 32'd0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
